wb_bus_tracer: RTL and testbench
================================

# wb_bus_tracer

Synthesizable, parametrised Wishbone transaction tracer that passively snoops a CPU data bus and records every qualified completed access (stb && ack) into an on-chip FIFO. Each entry holds address, data, direction, byte-select and a cycle timestamp. It sits beside the bus interconnect inside soc_top as a hardware debug aid, drained through a valid/ready stream by a debug UART bridge or a CPU-visible register block.

## Interface
Parameters:
- ADDR_W, 32, snooped address width
- DATA_W, 32, snooped data width; multiple of 8; sel width SEL_W = DATA_W/8
- DEPTH, 16, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp width
- NUM_FILT, 2, number of address base/mask filters, >= 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of FIFO, counters, flags
- cfg_enable  in  1  capture and timestamp enable
- cfg_overwrite  in  1  0 = stop-when-full, 1 = overwrite oldest
- cfg_cap_reads  in  1  capture read accesses
- cfg_cap_writes  in  1  capture write accesses
- cfg_filt_en  in  NUM_FILT  per-filter enable
- cfg_filt_base  in  NUM_FILT*ADDR_W  filter i base at [i*ADDR_W +: ADDR_W]
- cfg_filt_mask  in  NUM_FILT*ADDR_W  filter i mask, same packing
- mon_stb, mon_ack, mon_we  in  1  snooped bus strobe, ack, write enable
- mon_sel  in  SEL_W  snooped byte select
- mon_addr  in  ADDR_W  snooped address
- mon_dat_w  in  DATA_W  master-to-slave data
- mon_dat_r  in  DATA_W  slave-to-master data
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_addr  out  ADDR_W;  out_data  out  DATA_W;  out_we  out  1;  out_sel  out  SEL_W;  out_ts  out  TS_W  head entry fields
- level  out  $clog2(DEPTH)+1  entries stored
- overflow  out  1  sticky: at least one event dropped or overwritten
- drop_cnt  out  16  saturating count of lost events

## Operation
- Event = mon_stb && mon_ack && cfg_enable && type_ok && addr_ok, sampled at rising clk.
- type_ok = (mon_we && cfg_cap_writes) || (!mon_we && cfg_cap_reads).
- addr_ok = 1 if cfg_filt_en == 0; else OR over enabled i of ((mon_addr & mask_i) == (base_i & mask_i)).
- Entry data = mon_dat_w if mon_we else mon_dat_r; ts = timestamp counter value at the capture edge (pre-increment).
- Timestamp: TS_W-bit counter, +1 per cycle while cfg_enable, wraps to 0, holds when disabled.
- Pop = out_valid && out_ready. Push and pop may occur in the same cycle.
- Full, no pop, stop mode: event dropped; FIFO unchanged; overflow <= 1; drop_cnt +1.
- Full, no pop, overwrite mode: event written; oldest entry discarded (read and write pointers advance); level stays DEPTH; overflow <= 1; drop_cnt +1.
- Full with pop, either mode: push accepted, level unchanged, no drop.
- Empty with event: entry stored; no same-cycle fall-through.
- drop_cnt saturates at 16'hFFFF.
- Events while cfg_enable = 0 are ignored and never counted.
- clear has priority over push and pop in the same cycle: pointers, level, overflow, drop_cnt, timestamp <= 0.

## Timing
- Reset values: out_valid 0, level 0, overflow 0, drop_cnt 0, timestamp 0, pointers 0.
- out_addr/out_data/out_we/out_sel/out_ts are forced to 0 whenever out_valid = 0, including after reset. Storage array is not reset.
- Latency: an event sampled at edge k makes out_valid = 1 and level updated in the cycle after edge k.
- out_valid = (level != 0), derived from registers. Head fields are read combinationally from storage at the read pointer.
- Head fields are stable while out_valid && !out_ready, except in overwrite mode when full, where an overwrite advances the head.
- Reset asserted mid-operation clears all state asynchronously. Outputs take reset values immediately. Capture resumes on the first edge after rst_n rises.
- Throughput: one push and one pop per cycle.

## Test plan
- Write 0x12345678 to 0x00010004 with sel 4'hF, all filters disabled, both types enabled -> next cycle out_valid = 1, out_addr 0x00010004, out_data 0x12345678, out_we 1, out_ts = capture-edge count; level 1.
- Filter 0 base 0x40000000, mask 0xF0000000, enabled; accesses to 0x40000010 and 0x00000100 -> only 0x40000010 captured; level 1.
- Stop mode, DEPTH 16, out_ready 0, 20 events -> level 16; overflow 1; drop_cnt 4; drained entries are events 1..16 in order.
- Overwrite mode, same stimulus -> level 16; drop_cnt 4; drained entries are events 5..20.
- Full FIFO, event and pop in the same cycle -> level stays 16, drop_cnt unchanged; then clear together with an event -> level 0, overflow 0, drop_cnt 0, nothing captured.
- cfg_cap_reads 0 with a read of 0xDEADBEEF -> no entry; rst_n pulsed low mid-burst -> out_valid 0 and level 0 immediately.

Source files
------------

// File: rtl/wb_bus_tracer.sv
// Purpose : passive Wishbone snooper; every qualified completed access (stb && ack)
//           is pushed into a DEPTH-entry trace FIFO with addr/data/we/sel/timestamp.
// Latency : event sampled at edge k is visible at the FIFO head in the cycle after edge k.
// Backpr. : out_valid/out_ready stream; when full, events are dropped (stop mode) or
//           replace the oldest entry (overwrite mode), both counted in drop_cnt.
// Ports   : clk/rst_n (async active-low), clear (sync flush), cfg_* capture controls and
//           address filters, mon_* snooped bus, out_* head entry stream,
//           level/overflow/drop_cnt status.
module wb_bus_tracer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 16,
  parameter int NUM_FILT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       cfg_enable,
  input  logic                       cfg_overwrite,
  input  logic                       cfg_cap_reads,
  input  logic                       cfg_cap_writes,
  input  logic [NUM_FILT-1:0]        cfg_filt_en,
  input  logic [NUM_FILT*ADDR_W-1:0] cfg_filt_base,
  input  logic [NUM_FILT*ADDR_W-1:0] cfg_filt_mask,
  input  logic                       mon_stb,
  input  logic                       mon_ack,
  input  logic                       mon_we,
  input  logic [DATA_W/8-1:0]        mon_sel,
  input  logic [ADDR_W-1:0]          mon_addr,
  input  logic [DATA_W-1:0]          mon_dat_w,
  input  logic [DATA_W-1:0]          mon_dat_r,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_we,
  output logic [DATA_W/8-1:0]        out_sel,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W + 1 + SEL_W + TS_W;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TS_W-1:0]   ts_cnt;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;

  logic              addr_ok;
  logic              type_ok;
  logic              evt;
  logic              full;
  logic              pop;
  logic              drop;
  logic              push;
  logic              adv_rd;

  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic              h_we;
  logic [SEL_W-1:0]  h_sel;
  logic [TS_W-1:0]   h_ts;

  // No enabled filter means "match everything"; otherwise any enabled filter may hit.
  always_comb begin
    addr_ok = (cfg_filt_en == '0);
    for (int i = 0; i < NUM_FILT; i++) begin
      if (cfg_filt_en[i] &&
          ((mon_addr & cfg_filt_mask[i*ADDR_W +: ADDR_W]) ==
           (cfg_filt_base[i*ADDR_W +: ADDR_W] & cfg_filt_mask[i*ADDR_W +: ADDR_W])))
        addr_ok = 1'b1;
    end
  end

  assign type_ok   = (mon_we && cfg_cap_writes) || (!mon_we && cfg_cap_reads);
  assign evt       = mon_stb && mon_ack && cfg_enable && type_ok && addr_ok;
  assign full      = (level == LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees a slot, so only a full FIFO without a pop loses an event.
  assign drop      = evt && full && !pop;
  assign push      = evt && (!drop || cfg_overwrite);
  // Overwrite of a full FIFO discards the oldest entry by advancing the read side too.
  assign adv_rd    = pop || (drop && cfg_overwrite);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      ts_cnt   <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      ts_cnt   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (adv_rd)
        rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(adv_rd);
      if (drop)
        overflow <= 1'b1;
      if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (cfg_enable)
        ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // Storage is intentionally not reset; head fields are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= {mon_addr, (mon_we ? mon_dat_w : mon_dat_r), mon_we, mon_sel, ts_cnt};
  end

  assign head = mem[rd_ptr];
  assign {h_addr, h_data, h_we, h_sel, h_ts} = head;

  assign out_addr = out_valid ? h_addr : '0;
  assign out_data = out_valid ? h_data : '0;
  assign out_we   = out_valid ? h_we   : 1'b0;
  assign out_sel  = out_valid ? h_sel  : '0;
  assign out_ts   = out_valid ? h_ts   : '0;

endmodule

// File: tb/tb_wb_bus_tracer.sv
module tb_wb_bus_tracer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        cfg_enable, cfg_overwrite, cfg_cap_reads, cfg_cap_writes;
  logic [1:0]  cfg_filt_en;
  logic [63:0] cfg_filt_base, cfg_filt_mask;
  logic        mon_stb, mon_ack, mon_we;
  logic [3:0]  mon_sel;
  logic [31:0] mon_addr, mon_dat_w, mon_dat_r;
  logic        out_valid, out_ready, out_we, overflow;
  logic [31:0] out_addr, out_data;
  logic [3:0]  out_sel;
  logic [15:0] out_ts, drop_cnt;
  logic [4:0]  level;

  wb_bus_tracer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TS_W(16), .NUM_FILT(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .cfg_enable(cfg_enable), .cfg_overwrite(cfg_overwrite),
    .cfg_cap_reads(cfg_cap_reads), .cfg_cap_writes(cfg_cap_writes),
    .cfg_filt_en(cfg_filt_en), .cfg_filt_base(cfg_filt_base), .cfg_filt_mask(cfg_filt_mask),
    .mon_stb(mon_stb), .mon_ack(mon_ack), .mon_we(mon_we), .mon_sel(mon_sel),
    .mon_addr(mon_addr), .mon_dat_w(mon_dat_w), .mon_dat_r(mon_dat_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_we(out_we), .out_sel(out_sel), .out_ts(out_ts),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: trace buffer as a queue of recorded accesses.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic [3:0]  sel;
    logic [15:0] ts;
  } ent_t;

  ent_t        q[$];
  int          m_drop;
  bit          m_ovf;
  logic [15:0] m_ts;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  fen;
    logic        we, cr, cw, stb, ack;
    logic [31:0] addr;
    logic        exp;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_ovf  = 0;
    m_ts   = '0;
  endtask

  // Applies the recording rules to the inputs that are present at the coming edge.
  task automatic model_edge();
    bit   pop, aok, evt;
    ent_t e;
    if (clear) begin
      model_reset();
      return;
    end
    pop = (q.size() != 0) && out_ready;
    aok = (cfg_filt_en == 2'b00);
    for (int i = 0; i < 2; i++)
      if (cfg_filt_en[i] && ((mon_addr & cfg_filt_mask[i*32 +: 32]) ==
                             (cfg_filt_base[i*32 +: 32] & cfg_filt_mask[i*32 +: 32])))
        aok = 1;
    evt = mon_stb && mon_ack && cfg_enable && aok &&
          (mon_we ? cfg_cap_writes : cfg_cap_reads);
    e.a = mon_addr; e.d = mon_we ? mon_dat_w : mon_dat_r;
    e.we = mon_we; e.sel = mon_sel; e.ts = m_ts;
    if (pop) void'(q.pop_front());
    if (evt) begin
      if (q.size() == DEPTH) begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1;
        if (cfg_overwrite) begin
          void'(q.pop_front());
          q.push_back(e);
        end
      end else begin
        q.push_back(e);
      end
    end
    if (cfg_enable) m_ts = m_ts + 16'd1;
  endtask

  task automatic check_outputs();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk("out_valid", out_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("out_addr", out_addr, h.a);
    chk("out_data", out_data, h.d);
    chk("out_we", out_we, h.we);
    chk("out_sel", out_sel, h.sel);
    chk("out_ts", out_ts, h.ts);
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_evt(input logic we, input logic [31:0] addr, input logic [31:0] dat);
    mon_stb = 1'b1; mon_ack = 1'b1; mon_we = we; mon_sel = 4'hF;
    mon_addr = addr; mon_dat_w = dat; mon_dat_r = ~dat;
  endtask

  task automatic set_idle();
    mon_stb = 1'b0; mon_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    set_idle(); out_ready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    cfg_enable = 1'b0; cfg_overwrite = 1'b0; cfg_cap_reads = 1'b1; cfg_cap_writes = 1'b1;
    cfg_filt_en = 2'b00; cfg_filt_base = '0; cfg_filt_mask = '0;
    mon_stb = 1'b0; mon_ack = 1'b0; mon_we = 1'b0; mon_sel = 4'h0;
    mon_addr = '0; mon_dat_w = '0; mon_dat_r = '0; out_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_out_addr", out_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, filters off; timestamp starts at 0 on the first enabled edge
    cfg_enable = 1'b1;
    set_evt(1'b1, 32'h00010004, 32'h12345678);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_addr", out_addr, 32'h00010004);
    chk("t1_data", out_data, 32'h12345678);
    chk("t1_we", out_we, 1);
    chk("t1_sel", out_sel, 4'hF);
    chk("t1_ts", out_ts, 0);
    chk("t1_level", level, 1);
    set_idle(); out_ready = 1'b1;
    step();
    chk("t1_drain_level", level, 0);

    // Filter / type qualification table; out_ready=1 pops each capture one cycle later
    cfg_filt_base = {32'h00002000, 32'h40000000};
    cfg_filt_mask = {32'hFFFFF000, 32'hF0000000};
    vt[0] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40000010, 1'b1};
    vt[1] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000100, 1'b0};
    vt[2] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40000020, 1'b0};
    vt[3] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4ABCDEF0, 1'b1};
    vt[4] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40000000, 1'b0};
    vt[5] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40000000, 1'b0};
    vt[6] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00002ABC, 1'b1};
    vt[7] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40000010, 1'b0};
    vt[8] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1};
    vt[9] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40000010, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cfg_filt_en = vt[i].fen; cfg_cap_reads = vt[i].cr; cfg_cap_writes = vt[i].cw;
      set_evt(vt[i].we, vt[i].addr, vt[i].addr ^ 32'hA5A5A5A5);
      mon_stb = vt[i].stb; mon_ack = vt[i].ack;
      step();
      chk("vec_level", level, {4'b0, vt[i].exp});
      if (vt[i].exp) chk("vec_addr", out_addr, vt[i].addr);
    end
    set_idle(); cfg_filt_en = 2'b00; cfg_cap_reads = 1'b1; cfg_cap_writes = 1'b1;
    step();

    // Stop mode: 20 events into 16 slots, first 16 kept
    out_ready = 1'b0; cfg_overwrite = 1'b0;
    for (int i = 1; i <= 20; i++) begin set_evt(1'b1, i, 32'h1000 + i); step(); end
    chk("stop_level", level, 16);
    chk("stop_overflow", overflow, 1);
    chk("stop_drop_cnt", drop_cnt, 4);
    set_idle(); out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin chk("stop_order", out_addr, i); step(); end
    chk("stop_empty", level, 0);
    pulse_clear();

    // Overwrite mode: newest 16 kept
    cfg_overwrite = 1'b1;
    for (int i = 1; i <= 20; i++) begin set_evt(1'b1, i, 32'h2000 + i); step(); end
    chk("ovw_level", level, 16);
    chk("ovw_drop_cnt", drop_cnt, 4);
    chk("ovw_overflow", overflow, 1);
    set_idle(); out_ready = 1'b1;
    for (int i = 5; i <= 20; i++) begin chk("ovw_order", out_addr, i); step(); end
    pulse_clear();

    // Full FIFO with simultaneous push and pop, disabled events, then clear with an event
    cfg_overwrite = 1'b0;
    for (int i = 1; i <= 16; i++) begin set_evt(1'b0, 32'h300 + i, i); step(); end
    set_evt(1'b1, 32'h400, 32'h55); out_ready = 1'b1;
    step();
    chk("pp_level", level, 16);
    chk("pp_drop_cnt", drop_cnt, 0);
    out_ready = 1'b0;
    step();
    chk("full_drop_cnt", drop_cnt, 1);
    cfg_enable = 1'b0;
    step();
    chk("dis_drop_cnt", drop_cnt, 1);
    cfg_enable = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_level", level, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    chk("clr_valid", out_valid, 0);

    // Reads not captured when cfg_cap_reads = 0
    cfg_cap_reads = 1'b0;
    set_evt(1'b0, 32'h00000200, 32'hDEADBEEF); mon_dat_r = 32'hDEADBEEF;
    step();
    chk("noread_level", level, 0);
    cfg_cap_reads = 1'b1;

    // Randomized traffic with a mid-burst asynchronous reset
    cfg_filt_base = {32'h00000100, 32'h40000000};
    cfg_filt_mask = {32'hF0000F00, 32'hF0000000};
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 0) begin
        cfg_overwrite  = 1'($urandom_range(0, 1));
        cfg_filt_en    = 2'($urandom_range(0, 3));
        cfg_cap_reads  = ($urandom_range(0, 3) != 0);
        cfg_cap_writes = ($urandom_range(0, 3) != 0);
      end
      if (c == 300) begin
        set_evt(1'b1, 32'h40000000, 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
      end
      cfg_enable = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 63) == 0);
      out_ready  = ($urandom_range(0, 2) == 0);
      mon_stb    = ($urandom_range(0, 3) != 0);
      mon_ack    = ($urandom_range(0, 3) != 0);
      mon_we     = 1'($urandom_range(0, 1));
      mon_sel    = 4'($urandom_range(0, 15));
      mon_addr   = ($urandom() & 32'h0FFFFFFF) | ($urandom_range(0, 1) ? 32'h40000000 : 32'h0);
      mon_dat_w  = $urandom();
      mon_dat_r  = $urandom();
      step();
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
